// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the two-requester APB arbitrating master.
package apb_arb_pkg;

  localparam int NREQ  = 2;
  localparam int APB_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Index of the set bit in a one-hot two-requester grant vector.
  function automatic logic grant_idx(input logic [NREQ-1:0] g);
    return g[1];
  endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// Two-way round-robin arbiter: combinational one-hot grant, last-grant pointer
// updated only when the master accepts the grant.
module apb_rr_arbiter
  import apb_arb_pkg::*;
(
  input  logic            pclk,
  input  logic            presetn,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant
);

  // last_q holds the index of the most recent winner; resetting it to 1
  // gives requester 0 priority on the first contended cycle.
  logic last_q;

  always_comb begin
    grant = '0;
    if (req[0] && req[1]) begin
      grant = last_q ? 2'b01 : 2'b10;
    end else begin
      grant = req;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      last_q <= 1'b1;
    end else if (advance && (|req)) begin
      last_q <= grant_idx(grant);
    end
  end

endmodule

// File: rtl/apb_arb_master.sv
// APB master shared by two requesters with round-robin arbitration.
// Optional ACCESS timeout enabled by defining APB_ARB_TIMEOUT_EN.
module apb_arb_master
  import apb_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   pclk,
  input  logic                   presetn,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*APB_W-1:0]  req_addr,
  input  logic [NREQ*APB_W-1:0]  req_wdata,
  input  logic [NREQ-1:0]        req_write,
  output logic [NREQ-1:0]        ack,
  output logic [APB_W-1:0]       rsp_rdata,
  output logic                   rsp_err,
  output logic                   busy,
  output logic [APB_W-1:0]       paddr,
  output logic [APB_W-1:0]       pwdata,
  output logic                   psel,
  output logic                   penable,
  output logic                   pwrite,
  input  logic                   pready,
  input  logic                   pslverr,
  input  logic [APB_W-1:0]       prdata
);

  state_t          state_q;
  logic [NREQ-1:0] grant_q;
  logic [NREQ-1:0] gnt;
  logic            advance;
  logic            widx;
  logic [APB_W-1:0] sel_addr;
  logic [APB_W-1:0] sel_wdata;
  logic             sel_write;

  if (TIMEOUT_CYCLES < 1) begin : g_cfg_chk
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  // Requests are only looked at in IDLE, so the pointer moves once per grant.
  assign advance = (state_q == IDLE);

  apb_rr_arbiter u_arb (
    .pclk    (pclk),
    .presetn (presetn),
    .req     (req),
    .advance (advance),
    .grant   (gnt)
  );

  assign widx = grant_idx(gnt);

  always_comb begin
    sel_addr  = req_addr[APB_W-1:0];
    sel_wdata = req_wdata[APB_W-1:0];
    sel_write = req_write[0];
    if (widx) begin
      sel_addr  = req_addr[2*APB_W-1:APB_W];
      sel_wdata = req_wdata[2*APB_W-1:APB_W];
      sel_write = req_write[1];
    end
  end

`ifdef APB_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q;
  logic             tmo_hit;

  // Hit on the last permitted ACCESS cycle, so psel is high for exactly
  // TIMEOUT_CYCLES ACCESS cycles before the abort.
  assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      ack       <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
      tmo_q     <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            grant_q <= gnt;
            paddr   <= sel_addr;
            pwdata  <= sel_wdata;
            pwrite  <= sel_write;
            psel    <= 1'b1;
            penable <= 1'b0;
            busy    <= 1'b1;
            state_q <= SETUP;
          end
        end

        SETUP: begin
          penable <= 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
          tmo_q   <= '0;
`endif
          state_q <= ACCESS;
        end

        ACCESS: begin
          if (pready) begin
            rsp_rdata <= pwrite ? '0 : prdata;
            rsp_err   <= pslverr;
            ack       <= grant_q;
            psel      <= 1'b0;
            penable   <= 1'b0;
            state_q   <= DONE;
          end
`ifdef APB_ARB_TIMEOUT_EN
          else if (tmo_hit) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            ack       <= grant_q;
            psel      <= 1'b0;
            penable   <= 1'b0;
            state_q   <= DONE;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
`endif
        end

        DONE: begin
          ack       <= '0;
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
          busy      <= 1'b0;
          state_q   <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_arb_master.sv
// Directed bench for apb_arb_master: acts as the two requesters and the APB slave.
module tb_apb_arb_master;
  import apb_arb_pkg::*;

  logic                  pclk = 1'b0;
  logic                  presetn;
  logic [NREQ-1:0]       req;
  logic [NREQ*APB_W-1:0] req_addr;
  logic [NREQ*APB_W-1:0] req_wdata;
  logic [NREQ-1:0]       req_write;
  logic [NREQ-1:0]       ack;
  logic [APB_W-1:0]      rsp_rdata;
  logic                  rsp_err;
  logic                  busy;
  logic [APB_W-1:0]      paddr;
  logic [APB_W-1:0]      pwdata;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic                  pready;
  logic                  pslverr;
  logic [APB_W-1:0]      prdata;

  int errors = 0;
  int checks = 0;

  always #5 pclk = ~pclk;

  apb_arb_master #(.TIMEOUT_CYCLES(16)) dut (
    .pclk      (pclk),
    .presetn   (presetn),
    .req       (req),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_write (req_write),
    .ack       (ack),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .pready    (pready),
    .pslverr   (pslverr),
    .prdata    (prdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_port(input int idx, input logic [31:0] a, input logic [31:0] d,
                          input logic w);
    if (idx == 0) begin
      req_addr[31:0]  = a;
      req_wdata[31:0] = d;
      req_write[0]    = w;
    end else begin
      req_addr[63:32]  = a;
      req_wdata[63:32] = d;
      req_write[1]     = w;
    end
  endtask

  // Called on a negedge; waits for SETUP, acts as the slave, returns at the DONE negedge.
  task automatic xfer(input string tag, input int waits, input logic [31:0] rd,
                      input logic err, output int lat, output int acc,
                      output logic [31:0] a_seen, output logic [31:0] d_seen,
                      output logic w_seen);
    int n;
    lat = 0;
    acc = 0;
    a_seen = '0;
    d_seen = '0;
    w_seen = 1'b0;
    while (!psel && lat < 20) begin
      @(negedge pclk);
      lat++;
    end
    if (!psel) begin
      check({tag, "_psel_wait"}, 32'd0, 32'd1);
      return;
    end
    check({tag, "_setup_penable"}, 32'(penable), 32'd0);
    a_seen = paddr;
    d_seen = pwdata;
    w_seen = pwrite;
    @(negedge pclk);
    n = 0;
    while (psel && penable && n < 64) begin
      acc++;
      pready  = (n == waits);
      prdata  = rd;
      pslverr = err;
      n++;
      @(negedge pclk);
    end
    pready  = 1'b0;
    prdata  = '0;
    pslverr = 1'b0;
    if (n >= 64) check({tag, "_access_bound"}, 32'(n), 32'd0);
  endtask

  int          lat, acc;
  logic [31:0] a_seen, d_seen;
  logic        w_seen;
  logic [1:0]  exp_ack;

  initial begin
    presetn = 1'b0;
    req = '0;
    req_addr = '0;
    req_wdata = '0;
    req_write = '0;
    pready = 1'b0;
    pslverr = 1'b0;
    prdata = '0;

    repeat (2) @(negedge pclk);
    check("rst_psel", 32'(psel), 32'd0);
    check("rst_penable", 32'(penable), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_paddr", paddr, 32'd0);
    check("rst_pwdata", pwdata, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", 32'(rsp_err), 32'd0);
    presetn = 1'b1;
    @(negedge pclk);

    // Zero-wait write from requester 0; slave drives junk prdata that must be ignored.
    set_port(0, 32'h0, 32'hDEADBEEF, 1'b1);
    req = 2'b01;
    xfer("wr0", 0, 32'hFFFF0000, 1'b0, lat, acc, a_seen, d_seen, w_seen);
    check("wr0_latency", 32'(lat), 32'd1);
    check("wr0_access_cycles", 32'(acc), 32'd1);
    check("wr0_paddr", a_seen, 32'h0);
    check("wr0_pwdata", d_seen, 32'hDEADBEEF);
    check("wr0_pwrite", 32'(w_seen), 32'd1);
    check("wr0_ack", 32'(ack), 32'h1);
    check("wr0_err", 32'(rsp_err), 32'd0);
    check("wr0_rdata", rsp_rdata, 32'd0);
    check("wr0_busy_done", 32'(busy), 32'd1);
    req = 2'b00;
    @(negedge pclk);
    check("wr0_ack_clear", 32'(ack), 32'd0);
    check("wr0_busy_idle", 32'(busy), 32'd0);

    // One-wait read from requester 1.
    set_port(1, 32'h0, 32'h0, 1'b0);
    req = 2'b10;
    xfer("rd1", 1, 32'h12345678, 1'b0, lat, acc, a_seen, d_seen, w_seen);
    check("rd1_access_cycles", 32'(acc), 32'd2);
    check("rd1_pwrite", 32'(w_seen), 32'd0);
    check("rd1_ack", 32'(ack), 32'h2);
    check("rd1_rdata", rsp_rdata, 32'h12345678);
    req = 2'b00;
    @(negedge pclk);
    check("rd1_ack_pulse", 32'(ack), 32'd0);
    check("rd1_rdata_clear", rsp_rdata, 32'd0);

    // Slave error, then a clean read.
    set_port(0, 32'h0C, 32'h0, 1'b0);
    req = 2'b01;
    xfer("err0", 0, 32'h0BAD0BAD, 1'b1, lat, acc, a_seen, d_seen, w_seen);
    check("err0_paddr", a_seen, 32'h0C);
    check("err0_ack", 32'(ack), 32'h1);
    check("err0_err", 32'(rsp_err), 32'd1);
    req = 2'b00;
    @(negedge pclk);
    set_port(0, 32'h10, 32'h0, 1'b0);
    req = 2'b01;
    xfer("ok0", 0, 32'hAAAA5555, 1'b0, lat, acc, a_seen, d_seen, w_seen);
    check("ok0_err", 32'(rsp_err), 32'd0);
    check("ok0_rdata", rsp_rdata, 32'hAAAA5555);
    req = 2'b00;
    @(negedge pclk);

    // Requester 0 won last, so contention now goes to 1; reset it mid-ACCESS.
    set_port(0, 32'h100, 32'h11, 1'b1);
    set_port(1, 32'h200, 32'h22, 1'b0);
    req = 2'b11;
    @(negedge pclk);
    check("rr_pre_rst_paddr", paddr, 32'h200);
    @(negedge pclk);
    check("rr_pre_rst_access", 32'(penable), 32'd1);
    presetn = 1'b0;
    #1;
    check("rst_mid_psel", 32'(psel), 32'd0);
    check("rst_mid_penable", 32'(penable), 32'd0);
    @(negedge pclk);
    check("rst_mid_ack", 32'(ack), 32'd0);
    presetn = 1'b1;

    // Four transfers with both requests held: 0,1,0,1 after reset.
    for (int k = 0; k < 4; k++) begin
      exp_ack = (k % 2 == 0) ? 2'b01 : 2'b10;
      xfer($sformatf("rr%0d", k), k % 2, 32'h5A5A0000 + 32'(k), 1'b0, lat, acc,
           a_seen, d_seen, w_seen);
      check($sformatf("rr%0d_ack", k), 32'(ack), 32'(exp_ack));
      check($sformatf("rr%0d_paddr", k), a_seen, (k % 2 == 0) ? 32'h100 : 32'h200);
    end
    req = 2'b00;
    @(negedge pclk);
    check("rr_idle_ack", 32'(ack), 32'd0);

    // Slave that never answers in time.
    set_port(0, 32'h40, 32'h0, 1'b0);
    req = 2'b01;
`ifdef APB_ARB_TIMEOUT_EN
    xfer("tmo", 1000, 32'hCAFEF00D, 1'b0, lat, acc, a_seen, d_seen, w_seen);
    check("tmo_access_cycles", 32'(acc), 32'd16);
    check("tmo_psel", 32'(psel), 32'd0);
    check("tmo_ack", 32'(ack), 32'h1);
    check("tmo_err", 32'(rsp_err), 32'd1);
    check("tmo_rdata", rsp_rdata, 32'd0);
`else
    xfer("slow", 20, 32'hCAFEF00D, 1'b0, lat, acc, a_seen, d_seen, w_seen);
    check("slow_access_cycles", 32'(acc), 32'd21);
    check("slow_ack", 32'(ack), 32'h1);
    check("slow_err", 32'(rsp_err), 32'd0);
    check("slow_rdata", rsp_rdata, 32'hCAFEF00D);
`endif
    req = 2'b00;
    @(negedge pclk);
    check("final_busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_arb_master.md
APB_ARB_MASTER -- requirements
Module: apb_arb_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, number of ACCESS cycles without pready before abort (used only with APB_ARB_TIMEOUT_EN).
REQ-002 pclk  input  1  single clock for all logic, rising edge.
REQ-003 presetn  input  1  reset, asynchronous assert, active-low.
REQ-004 req  input  2  per-requester transfer request; bit i = requester i.
REQ-005 req_addr  input  2x32  per-requester target address.
REQ-006 req_wdata  input  2x32  per-requester write data.
REQ-007 req_write  input  2  per-requester direction; 1 = write, 0 = read.
REQ-008 ack  output  2  one-cycle completion pulse to the granted requester.
REQ-009 rsp_rdata  output  32  read data, valid while ack != 0.
REQ-010 rsp_err  output  1  error flag, valid while ack != 0.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 paddr, pwdata  output  32 each  APB address and write data.
REQ-013 psel, penable, pwrite  output  1 each  APB control.
REQ-014 pready, pslverr  input  1 each  APB slave response.
REQ-015 prdata  input  32  APB read data.

Function
REQ-016 FSM states SHALL be IDLE, SETUP, ACCESS, DONE; all outputs SHALL be registered.
REQ-017 IDLE: if req != 0, the winner SHALL be granted, its addr/wdata/write latched into paddr/pwdata/pwrite, and the state SHALL go to SETUP with psel=1, penable=0.
REQ-018 Arbitration SHALL be round-robin: with both req bits set, the requester not granted last wins; after reset requester 0 has priority.
REQ-019 SETUP SHALL go unconditionally to ACCESS with psel=1, penable=1, and paddr/pwdata/pwrite held.
REQ-020 ACCESS SHALL hold all APB outputs until pready=1; on that edge it SHALL capture prdata (reads; 0 for writes) and pslverr, then go to DONE with psel=0, penable=0.
REQ-021 DONE SHALL assert ack[grant] for exactly one cycle with rsp_rdata/rsp_err, then go to IDLE unconditionally; req SHALL NOT be sampled in DONE.
REQ-022 A requester SHALL hold req/addr/wdata/write stable from assertion until its ack; req still high in the cycle after ack SHALL be treated as a new request.
REQ-023 Zero-wait latency: req sampled in IDLE at edge E0 -> SETUP after E0, ACCESS after E1, ack high after E2 when pready=1 at E2; each wait state adds one cycle.
REQ-024 Request changes on non-granted or granted ports while busy SHALL NOT affect the transfer in flight.
REQ-025 ack, rsp_rdata and rsp_err SHALL be 0 outside DONE.

Reset
REQ-026 presetn low SHALL immediately force IDLE, psel=penable=pwrite=0, paddr=pwdata=0, ack=0, rsp_rdata=0, rsp_err=0, busy=0, RR priority to requester 0.
REQ-027 Reset during SETUP/ACCESS SHALL abandon the transfer without issuing ack.

Configuration
REQ-028 With APB_ARB_TIMEOUT_EN defined, a counter SHALL count ACCESS cycles with pready=0; on reaching TIMEOUT_CYCLES the block SHALL drop psel/penable, go to DONE, and return rsp_err=1, rsp_rdata=0; the counter SHALL clear on entering ACCESS.
REQ-029 Without APB_ARB_TIMEOUT_EN, no counter SHALL exist and ACCESS SHALL wait indefinitely for pready.

Structure
REQ-030 Package apb_arb_pkg SHALL hold the FSM state enum typedef, constant NREQ=2, and the APB data/address width constant 32.
REQ-031 Round-robin grant and last-grant pointer SHALL live in sub-module apb_rr_arbiter (inputs req, advance; output one-hot grant).

Verification
REQ-032 req[0]=1 write addr 0x0 data 0xDEADBEEF, zero-wait slave -> one SETUP, one ACCESS with pwdata=0xDEADBEEF, ack=2'b01 with rsp_err=0.
REQ-033 req[1]=1 read addr 0x0, slave one wait state returning prdata=0x12345678 -> ack=2'b10, rsp_rdata=0x12345678, ack pulse exactly one cycle.
REQ-034 req=2'b11 held for four transfers from reset -> grant order 0,1,0,1, never two consecutive APB transfers to the same requester.
REQ-035 Read addr 0x0C with pslverr=1 on pready -> ack with rsp_err=1; next transfer rsp_err=0.
REQ-036 presetn pulsed low during ACCESS -> psel/penable low in the same cycle, no ack, next transfer grants requester 0 first.
REQ-037 APB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, pready held 0 -> psel drops after 16 ACCESS cycles, ack with rsp_err=1, rsp_rdata=0.
